// File: rtl/sim_finish_pkg.sv
// -----------------------------------------------------------------------------
// sim_finish_pkg
// Shared definitions for the simulation finish controller:
//   CNT_W    - width of every cycle / hold / drain counter
//   state_e  - 3-bit FSM state encoding, also driven out on sim_finish_ctrl.state
//   is_armed - true in the states where the monitor is actively counting
// -----------------------------------------------------------------------------
package sim_finish_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_PASS  = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

    function automatic logic is_armed(input state_e s);
        return (s == ST_WAIT) || (s == ST_HOLD) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sim_finish_ctrl_timer.sv
// -----------------------------------------------------------------------------
// sim_finish_timer
// Loadable, saturating up-counter with synchronous clear and a compare-equal
// flag. It is used for the hold/drain phase count and for the armed-cycle
// watchdog.
// Priority on each edge: clr > load > inc. Once the counter reaches all-ones
// it stays there.
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset, clears the count
//   clr      in   synchronous clear to zero
//   load     in   synchronous load of load_val
//   load_val in   value for load
//   inc      in   count up by one (saturating)
//   cmp_val  in   compare value
//   cnt      out  current count
//   eq       out  cnt == cmp_val
// -----------------------------------------------------------------------------
module sim_finish_timer
    import sim_finish_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] cnt,
    output logic         eq
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign eq  = (cnt_q == cmp_val);

endmodule

// File: rtl/sim_finish_ctrl.sv
// -----------------------------------------------------------------------------
// sim_finish_ctrl
// Watches a set of per-channel "done" indications and decides when a
// simulation has finished: all participating channels must report done for
// HOLD_CYC consecutive cycles, then DRAIN_CYC more cycles elapse before PASS.
// An optional watchdog forces FAIL after TIMEOUT_CYC armed cycles.
//
// Build option: define SIM_FINISH_CALL_EN to have the block print a one-line
// PASS/FAIL message and call $finish itself on the edge entering PASS or FAIL.
// Without it the block only drives its outputs.
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   en          in   arms the monitor; low returns to IDLE (except PASS/FAIL)
//   in          in   [NO_SIG] per-channel done indications
//   mask        in   [NO_SIG] 1 = channel participates
//   done_flags  out  [NO_SIG] registered per-channel flags
//   state       out  [3] current FSM state (sim_finish_pkg::state_e)
//   finish      out  high in PASS or FAIL
//   pass        out  high in PASS
//   timeout     out  high in FAIL
//   cyc_cnt     out  [32] armed-cycle count, saturating
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not armed, flags and counters held at zero
// WAIT  | armed, waiting for all participating channels to be done
// HOLD  | all done seen, counting consecutive all-done cycles
// DRAIN | hold met, letting the run settle for DRAIN_CYC cycles
// PASS  | terminal success, left only by reset
// FAIL  | terminal watchdog expiry, left only by reset
// -----------------------------------------------------------------------------
module sim_finish_ctrl
    import sim_finish_pkg::*;
#(
    parameter int NO_SIG      = 1,
    parameter int HOLD_CYC    = 1,
    parameter int DRAIN_CYC   = 0,
    parameter int TIMEOUT_CYC = 0,
    parameter int STICKY      = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [NO_SIG-1:0] in,
    input  logic [NO_SIG-1:0] mask,
    output logic [NO_SIG-1:0] done_flags,
    output logic [2:0]        state,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       cyc_cnt
);

    // Compare targets are "count - 1" because the transition edge is the
    // one on which the counter would reach the required number of cycles.
    localparam logic [CNT_W-1:0] HOLD_TGT  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_TGT = (DRAIN_CYC > 0) ? CNT_W'(DRAIN_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] TO_TGT    = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e            state_q;
    state_e            state_d;
    logic [NO_SIG-1:0] done_flags_q;
    logic [NO_SIG-1:0] done_flags_d;

    logic              armed;
    logic              all_done;
    logic              hold_ok;

    logic              phase_clr;
    logic              phase_load;
    logic [CNT_W-1:0]  phase_cmp;
    logic [CNT_W-1:0]  phase_cnt_unused;
    logic              phase_eq;

    logic              wd_clr;
    logic [CNT_W-1:0]  wd_cnt;
    logic              wd_eq;
    logic              wd_hit;

    assign armed    = is_armed(state_q);
    assign all_done = (&(done_flags_q | ~mask)) && (|mask);
    assign hold_ok  = (state_q == ST_HOLD) && all_done;

    // Per-channel flags
    always_comb begin
        done_flags_d = done_flags_q;
        if ((state_q == ST_IDLE) || (armed && !en)) begin
            done_flags_d = '0;
        end else if (STICKY != 0) begin
            done_flags_d = done_flags_q | in;
        end else begin
            done_flags_d = in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_flags_q <= '0;
        end else begin
            done_flags_q <= done_flags_d;
        end
    end

    // HOLD and DRAIN never overlap, so one counter serves both phases. It
    // runs only while an uninterrupted hold or a drain is in progress and is
    // reloaded with zero on the HOLD->DRAIN edge so the drain starts fresh.
    assign phase_clr  = !en || !(hold_ok || (state_q == ST_DRAIN));
    assign phase_load = hold_ok && phase_eq;
    assign phase_cmp  = (state_q == ST_DRAIN) ? DRAIN_TGT : HOLD_TGT;

    sim_finish_timer #(
        .W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (phase_clr),
        .load     (phase_load),
        .load_val ('0),
        .inc      (1'b1),
        .cmp_val  (phase_cmp),
        .cnt      (phase_cnt_unused),
        .eq       (phase_eq)
    );

    // Armed-cycle counter doubling as the watchdog
    assign wd_clr = (state_q == ST_IDLE) || (armed && !en);

    sim_finish_timer #(
        .W (CNT_W)
    ) u_wd_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (armed),
        .cmp_val  (TO_TGT),
        .cnt      (wd_cnt),
        .eq       (wd_eq)
    );

    assign wd_hit = (TIMEOUT_CYC > 0) && wd_eq;

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en) state_d = ST_WAIT;
            ST_WAIT:  if (all_done) state_d = ST_HOLD;
            ST_HOLD: begin
                if (!all_done) begin
                    state_d = ST_WAIT;
                end else if (phase_eq) begin
                    state_d = (DRAIN_CYC == 0) ? ST_PASS : ST_DRAIN;
                end
            end
            ST_DRAIN: if (phase_eq) state_d = ST_PASS;
            ST_PASS:  state_d = ST_PASS;
            ST_FAIL:  state_d = ST_FAIL;
            default:  state_d = ST_IDLE;
        endcase
        // Disarm wins over everything; a same-edge PASS beats the watchdog.
        if (armed) begin
            if (!en) begin
                state_d = ST_IDLE;
            end else if (wd_hit && (state_d != ST_PASS)) begin
                state_d = ST_FAIL;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        finish  = 1'b0;
        pass    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            ST_PASS: begin
                finish = 1'b1;
                pass   = 1'b1;
            end
            ST_FAIL: begin
                finish  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = state_q;
    assign done_flags = done_flags_q;
    assign cyc_cnt    = wd_cnt;

`ifdef SIM_FINISH_CALL_EN
    // The entry edge is itself an armed cycle, so the reported count is the
    // value cyc_cnt takes on that edge.
    always @(posedge clk) begin
        if (rstn && (state_d != state_q) &&
            ((state_d == ST_PASS) || (state_d == ST_FAIL))) begin
            $display("sim_finish_ctrl: %s cyc_cnt=%0d",
                     (state_d == ST_PASS) ? "PASS" : "FAIL",
                     (wd_cnt == {CNT_W{1'b1}}) ? wd_cnt : wd_cnt + CNT_W'(1));
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_sim_finish_ctrl.sv
module tb_sim_finish_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [2:0] in;
    logic [2:0] mask;

    // a: HOLD=2 DRAIN=4 no watchdog, sticky
    // b: HOLD=3 no drain, non-sticky
    // c: HOLD=1 no drain, watchdog 50
    // d: HOLD=2 DRAIN=4 watchdog 16 (timeout lands on the drain-end edge)
    logic [2:0]  flags_a, flags_b, flags_c, flags_d;
    logic [2:0]  state_a, state_b, state_c, state_d;
    logic        fin_a, fin_b, fin_c, fin_d;
    logic        pass_a, pass_b, pass_c, pass_d;
    logic        to_a, to_b, to_c, to_d;
    logic [31:0] cyc_a, cyc_b, cyc_c, cyc_d;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_WAIT  = 32'd1;
    localparam logic [31:0] S_HOLD  = 32'd2;
    localparam logic [31:0] S_DRAIN = 32'd3;
    localparam logic [31:0] S_PASS  = 32'd4;
    localparam logic [31:0] S_FAIL  = 32'd5;

    sim_finish_ctrl #(.NO_SIG(3), .HOLD_CYC(2), .DRAIN_CYC(4), .TIMEOUT_CYC(0), .STICKY(1)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .in(in), .mask(mask),
        .done_flags(flags_a), .state(state_a), .finish(fin_a), .pass(pass_a),
        .timeout(to_a), .cyc_cnt(cyc_a));

    sim_finish_ctrl #(.NO_SIG(3), .HOLD_CYC(3), .DRAIN_CYC(0), .TIMEOUT_CYC(0), .STICKY(0)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .in(in), .mask(mask),
        .done_flags(flags_b), .state(state_b), .finish(fin_b), .pass(pass_b),
        .timeout(to_b), .cyc_cnt(cyc_b));

    sim_finish_ctrl #(.NO_SIG(3), .HOLD_CYC(1), .DRAIN_CYC(0), .TIMEOUT_CYC(50), .STICKY(1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .in(in), .mask(mask),
        .done_flags(flags_c), .state(state_c), .finish(fin_c), .pass(pass_c),
        .timeout(to_c), .cyc_cnt(cyc_c));

    sim_finish_ctrl #(.NO_SIG(3), .HOLD_CYC(2), .DRAIN_CYC(4), .TIMEOUT_CYC(16), .STICKY(1)) dut_d (
        .clk(clk), .rstn(rstn), .en(en), .in(in), .mask(mask),
        .done_flags(flags_d), .state(state_d), .finish(fin_d), .pass(pass_d),
        .timeout(to_d), .cyc_cnt(cyc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled off-edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset all DUTs, release 1 unit after an edge; the next edge is "edge 1".
    task automatic do_reset(input logic [2:0] m, input logic [2:0] v);
        rstn = 1'b0;
        en   = 1'b0;
        in   = 3'b000;
        mask = 3'b000;
        tick(2);
        rstn = 1'b1;
        en   = 1'b1;
        mask = m;
        in   = v;
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        in   = 3'b000;
        mask = 3'b000;
        tick(2);
        check("rst_state", 32'(state_a), S_IDLE);
        check("rst_flags", 32'(flags_a), 32'd0);
        check("rst_finish", 32'(fin_a), 32'd0);
        check("rst_cyc", cyc_a, 32'd0);

        // Nominal pass: in rises so edge 10 latches it, finish at edge 17.
        do_reset(3'b111, 3'b000);
        tick(1);
        check("arm_wait", 32'(state_a), S_WAIT);
        tick(8);
        in = 3'b111;
        tick(1);                                   // edge 10
        check("e10_flags", 32'(flags_a), 32'd7);
        check("e10_state", 32'(state_a), S_WAIT);
        tick(1);                                   // edge 11
        check("e11_hold", 32'(state_a), S_HOLD);
        tick(2);                                   // edge 13
        check("e13_drain", 32'(state_a), S_DRAIN);
        check("b_e13_hold", 32'(state_b), S_HOLD);
        tick(1);                                   // edge 14
        check("b_e14_pass", 32'(pass_b), 32'd1);
        tick(2);                                   // edge 16
        check("e16_nofinish", 32'(fin_a), 32'd0);
        check("e16_drain", 32'(state_a), S_DRAIN);
        check("d_e16_drain", 32'(state_d), S_DRAIN);
        tick(1);                                   // edge 17
        check("e17_finish", 32'(fin_a), 32'd1);
        check("e17_pass", 32'(pass_a), 32'd1);
        check("e17_timeout", 32'(to_a), 32'd0);
        check("e17_cyc", cyc_a, 32'd16);
        check("coinc_pass", 32'(pass_d), 32'd1);
        check("coinc_timeout", 32'(to_d), 32'd0);
        en = 1'b0;
        tick(3);
        check("pass_terminal", 32'(state_a), S_PASS);
        check("pass_cyc_frozen", cyc_a, 32'd16);

        // Non-sticky hold broken by in[1] dropping, then a full fresh hold.
        do_reset(3'b111, 3'b000);
        tick(1);                                   // edge 1
        in = 3'b111;
        tick(2);                                   // edge 3
        check("b_hold_enter", 32'(state_b), S_HOLD);
        in = 3'b101;
        tick(2);                                   // edge 5
        check("b_back_wait", 32'(state_b), S_WAIT);
        check("b_flags_resample", 32'(flags_b), 32'd5);
        check("a_flags_sticky", 32'(flags_a), 32'd7);
        tick(5);                                   // edge 10
        check("b_no_finish", 32'(fin_b), 32'd0);
        check("b_still_wait", 32'(state_b), S_WAIT);
        in = 3'b111;
        tick(4);                                   // edge 14
        check("b_rehold_full", 32'(state_b), S_HOLD);
        tick(1);                                   // edge 15
        check("b_rehold_pass", 32'(pass_b), 32'd1);

        // Watchdog: in[2] never arrives.
        do_reset(3'b111, 3'b011);
        tick(50);                                  // edge 50
        check("c_e50_state", 32'(state_c), S_WAIT);
        check("c_e50_cyc", cyc_c, 32'd49);
        check("c_e50_timeout", 32'(to_c), 32'd0);
        tick(1);                                   // edge 51
        check("c_timeout", 32'(to_c), 32'd1);
        check("c_finish", 32'(fin_c), 32'd1);
        check("c_nopass", 32'(pass_c), 32'd0);
        check("c_cyc50", cyc_c, 32'd50);
        en = 1'b0;
        tick(3);
        check("c_fail_terminal", 32'(state_c), S_FAIL);
        check("c_cyc_frozen", cyc_c, 32'd50);

        // Partial mask: in[1] is ignored; flags latch at edge 2, pass at 9.
        do_reset(3'b101, 3'b101);
        tick(8);
        check("m101_e8_nopass", 32'(pass_a), 32'd0);
        tick(1);
        check("m101_e9_pass", 32'(pass_a), 32'd1);

        // Empty mask never completes.
        do_reset(3'b000, 3'b111);
        tick(30);
        check("m000_state", 32'(state_a), S_WAIT);
        check("m000_nopass", 32'(pass_a), 32'd0);
        check("m000_flags", 32'(flags_a), 32'd7);

        // Reset in DRAIN is asynchronous and discards progress.
        do_reset(3'b111, 3'b111);
        tick(6);
        check("r_in_drain", 32'(state_a), S_DRAIN);
        #3;
        rstn = 1'b0;
        #1;
        check("r_async_state", 32'(state_a), S_IDLE);
        check("r_async_flags", 32'(flags_a), 32'd0);
        check("r_async_cyc", cyc_a, 32'd0);
        check("r_async_finish", 32'(fin_a), 32'd0);
        en = 1'b0;
        in = 3'b000;
        tick(1);
        rstn = 1'b1;
        tick(20);
        check("r_after_idle", 32'(state_a), S_IDLE);
        check("r_after_nopass", 32'(pass_a), 32'd0);
        en = 1'b1;
        tick(10);
        check("r_rearm_wait", 32'(state_a), S_WAIT);
        check("r_rearm_flags", 32'(flags_a), 32'd0);
        check("r_rearm_cyc", cyc_a, 32'd9);

        // Disarm from WAIT returns to IDLE and clears the count.
        en = 1'b0;
        tick(1);
        check("dis_idle", 32'(state_a), S_IDLE);
        check("dis_cyc", cyc_a, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: observed=expired expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sim_finish_ctrl.md
SIM_FINISH_CTRL -- requirements
Module: sim_finish_ctrl

Interface
REQ-001 SHALL have parameter NO_SIG, default 1: number of monitored done inputs, range 1..32.
REQ-002 SHALL have parameter HOLD_CYC, default 1: consecutive cycles all-done must persist, minimum 1.
REQ-003 SHALL have parameter DRAIN_CYC, default 0: cycles between hold satisfied and finish; 0 means no drain.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 0: watchdog limit in cycles; 0 disables the watchdog.
REQ-005 SHALL have parameter STICKY, default 1: 1 latches each input once seen high; 0 re-samples every cycle.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port en, input, 1 bit: arms the monitor; low forces IDLE.
REQ-009 SHALL have port in, input, NO_SIG bits: per-channel done indications.
REQ-010 SHALL have port mask, input, NO_SIG bits: 1 = channel participates.
REQ-011 SHALL have port done_flags, output, NO_SIG bits: registered per-channel flags.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-013 SHALL have port finish, output, 1 bit: high in PASS or FAIL; sticky.
REQ-014 SHALL have port pass, output, 1 bit: high only in PASS.
REQ-015 SHALL have port timeout, output, 1 bit: high only in FAIL.
REQ-016 SHALL have port cyc_cnt, output, 32 bits: armed-cycle count, saturating at 2^32-1.

Function
REQ-017 SHALL register done_flags[i] each cycle: STICKY=1 -> flag |= in[i]; STICKY=0 -> flag = in[i].
REQ-018 SHALL compute all_done = &(done_flags | ~mask) && (|mask); an all-zero mask never yields all_done.
REQ-019 SHALL implement states IDLE, WAIT, HOLD, DRAIN, PASS, FAIL.
REQ-020 SHALL transition IDLE->WAIT on en=1.
REQ-021 SHALL transition WAIT->HOLD when all_done=1.
REQ-022 SHALL advance HOLD->DRAIN (or ->PASS if DRAIN_CYC=0) after all_done has been high for HOLD_CYC consecutive HOLD cycles.
REQ-023 SHALL transition HOLD->WAIT, clearing the hold count, if all_done drops before the hold requirement is met.
REQ-024 SHALL transition DRAIN->PASS after DRAIN_CYC cycles; all_done dropping during DRAIN SHALL be ignored.
REQ-025 SHALL assert finish exactly 1+HOLD_CYC+DRAIN_CYC rising edges after the edge that first makes all_done true, provided all_done stays high through HOLD.
REQ-026 SHALL increment cyc_cnt once per cycle in WAIT, HOLD and DRAIN.
REQ-027 SHALL, when TIMEOUT_CYC>0 and cyc_cnt reaches TIMEOUT_CYC, move to FAIL from WAIT, HOLD or DRAIN.
REQ-028 SHALL give PASS priority when PASS entry and timeout occur on the same edge.
REQ-029 SHALL treat PASS and FAIL as terminal; only reset leaves them, and en is ignored.
REQ-030 SHALL, on en=0 in WAIT, HOLD or DRAIN, return to IDLE at the next edge and clear cyc_cnt, the hold/drain counters and done_flags.
REQ-031 SHALL hold done_flags at zero while in IDLE.

Reset
REQ-032 SHALL, while rstn=0, immediately force state=IDLE, done_flags=0, finish=0, pass=0, timeout=0, cyc_cnt=0 and all internal counters to 0, independent of clk.
REQ-033 SHALL, when rstn asserts mid-operation (including in PASS or FAIL), discard all progress; after release the block requires a fresh en and fresh done inputs.

Configuration
REQ-034 SHALL, with macro SIM_FINISH_CALL_EN defined, display a one-line PASS/FAIL message with cyc_cnt and call $finish on the edge entering PASS or FAIL.
REQ-035 SHALL, without SIM_FINISH_CALL_EN, only drive the outputs, with no system tasks, so the block can sit under a higher-level bench controller.

Structure
REQ-036 SHALL take the state enumeration (3-bit encoding) and the counter width constant (32) from shared package sim_finish_pkg.
REQ-037 SHALL implement the hold/drain/watchdog counting in one sub-module, sim_finish_timer: a loadable, saturating up-counter with clear and a compare-equal flag.

Verification
REQ-038 Scenario: NO_SIG=3, HOLD_CYC=2, DRAIN_CYC=4, mask=3'b111; in driven to 3'b111 at edge 10 -> finish and pass rise at edge 17, timeout stays 0.
REQ-039 Scenario: STICKY=0, HOLD_CYC=3; in all-high for 2 cycles, then in[1] drops -> state returns to WAIT and no finish occurs.
REQ-040 Scenario: TIMEOUT_CYC=50, in[2] never asserted -> timeout and finish rise after 50 armed cycles, with cyc_cnt=50.
REQ-041 Scenario: mask=3'b101, in=3'b101 -> PASS reached; mask=3'b000 -> never PASS.
REQ-042 Scenario: rstn pulsed low during DRAIN -> all outputs 0 asynchronously; after release, no PASS without new en and new inputs.
REQ-043 Scenario: DRAIN end and timeout coincide -> pass=1, timeout=0.
